pulse_stretcher: RTL

- Sits directly downstream of the pulse generator and consumes its single-cycle pulse_sig events.
- Converts each accepted pulse into a fixed-width output pulse of WIDTH cycles.
- Enforces a minimum low gap of GAP cycles between output pulses.
- Pulses that arrive while busy are queued in a saturating pending counter; pulses dropped at saturation set a sticky overflow flag.

---
 rtl/pulse_stretcher.sv | 112 +++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into WIDTH-cycle pulses separated by at least GAP low cycles.
// state  | meaning
// IDLE   | no pulse in progress, nothing queued
// ACTIVE | driving stretch_out high for WIDTH cycles
// GAP    | holding the output low for GAP cycles before the next pulse
module pulse_stretcher #(
  parameter int WIDTH    = 4,
  parameter int GAP      = 2,
  parameter int MAX_PEND = 7,
  parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              stretch_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  WIDTH_LD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               decision;
  logic               drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    decision = 1'b0;
    drop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          state_d = ST_ACTIVE;
          cnt_d   = WIDTH_LD;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            decision = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) decision = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // A pulse arriving in the decision cycle is served immediately, never queued.
    if (decision) begin
      if ((pend_q != '0) || pulse_in) begin
        state_d = ST_ACTIVE;
        cnt_d   = WIDTH_LD;
        if (!pulse_in) pend_d = pend_q - PEND_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end else if ((state_q != ST_IDLE) && pulse_in) begin
      if (pend_q < PEND_MAX) pend_d = pend_q + PEND_W'(1);
      else                   drop   = 1'b1;
    end

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  assign stretch_out = (state_q == ST_ACTIVE);
  assign busy        = (state_q != ST_IDLE);
  assign pending     = pend_q;
  assign overflow    = ovf_q;

endmodule
